// File: rtl/i2s_frame_scheduler.sv
// i2s_frame_scheduler
//   Paces sample production for the I2S DAC transmitter. A 32-bit phase
//   accumulator produces the frame tick. On each tick the scheduler polls
//   every voice over a shared req/ack bus and sums the returned samples in
//   wide accumulators. It then saturates the sums into a stable 16-bit
//   signed L/R pair.
//
//   Optional build macro I2S_FRAME_GAIN_EN adds the voice_gain input. Each
//   sample is scaled by voice_gain/256 before it is accumulated.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   enable      allows the phase accumulator to advance
//   voice_req   request a sample from the voice on voice_sel
//   voice_sel   index of the voice being polled
//   voice_ack   voice_l/voice_r valid (accepted only while voice_req=1)
//   voice_l/r   signed samples from the selected voice
//   voice_gain  (I2S_FRAME_GAIN_EN only) unsigned Q0.8 gain, taken with the ack
//   l/r         mixed, saturated samples to the transmitter
//   frame_done  one-cycle pulse in the cycle l/r take a new value
//   overrun     sticky: a tick arrived while a frame was still running
//   missed      sticky per voice: that voice timed out
//   clr_flags   clears overrun/missed; a same-cycle flag event wins
module i2s_frame_scheduler #(
   parameter int VOICES  = 4,
   parameter int CLK_HZ  = 25000000,
   parameter int LRCK_HZ = 44100,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic              voice_req,
   output logic [3:0]        voice_sel,
   input  logic              voice_ack,
   input  logic [15:0]       voice_l,
   input  logic [15:0]       voice_r,
`ifdef I2S_FRAME_GAIN_EN
   input  logic [7:0]        voice_gain,
`endif
   output logic [15:0]       l,
   output logic [15:0]       r,
   output logic              frame_done,
   output logic              overrun,
   output logic [VOICES-1:0] missed,
   input  logic              clr_flags
);

   localparam logic [63:0] INC64 = ((64'd1 << 32) * 64'(LRCK_HZ)) / 64'(CLK_HZ);
   localparam logic [31:0] INC   = INC64[31:0];
   localparam int          ACC_W = 16 + $clog2(VOICES);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

   typedef enum logic [1:0] {IDLE, REQ, NEXT, MIX} state_t;

   state_t                   state, next_state;
   logic [31:0]              phase;
   logic                     tick;
   logic [7:0]               wait_cnt;
   logic                     accept, timed_out;
   logic signed [ACC_W-1:0]  acc_l, acc_r;
   logic signed [ACC_W-1:0]  add_l, add_r;
   logic [VOICES-1:0]        miss_mask;

   // Tick generator: tick is the registered carry out of the phase add.
   // NOTE: sequential state is always written with <=, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= '0;
         tick  <= 1'b0;
      end else if (enable) begin
         {tick, phase} <= {1'b0, phase} + {1'b0, INC};
      end else begin
         tick <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: every signal written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      voice_req  = 1'b0;
      accept     = 1'b0;
      timed_out  = 1'b0;
      unique case (state)
         IDLE: if (tick) next_state = REQ;
         REQ: begin
            voice_req = 1'b1;
            if (voice_ack) begin
               accept     = 1'b1;
               next_state = NEXT;
            end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
               timed_out  = 1'b1;
               next_state = NEXT;
            end
         end
         NEXT: next_state = (voice_sel == 4'(VOICES - 1)) ? MIX : REQ;
         MIX:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

`ifdef I2S_FRAME_GAIN_EN
   // 16-bit signed times 9-bit non-negative gain; the >>>8 result always fits 16 bits.
   logic signed [24:0] prod_l, prod_r;
   assign prod_l = $signed(voice_l) * $signed({1'b0, voice_gain});
   assign prod_r = $signed(voice_r) * $signed({1'b0, voice_gain});
   assign add_l  = ACC_W'($signed(prod_l[24:8]));
   assign add_r  = ACC_W'($signed(prod_r[24:8]));
`else
   assign add_l  = ACC_W'($signed(voice_l));
   assign add_r  = ACC_W'($signed(voice_r));
`endif

   assign miss_mask = timed_out ? (VOICES'(1) << voice_sel) : '0;

   function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
      if (a > SAT_MAX)      return 16'h7FFF;
      else if (a < SAT_MIN) return 16'h8000;
      else                  return a[15:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         voice_sel  <= '0;
         wait_cnt   <= '0;
         acc_l      <= '0;
         acc_r      <= '0;
         l          <= '0;
         r          <= '0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         missed     <= '0;
      end else begin
         frame_done <= 1'b0;
         // Counter is zero in every other state, so it restarts on each REQ entry.
         wait_cnt   <= (state == REQ) ? wait_cnt + 8'd1 : 8'd0;

         if (state == IDLE && tick) begin
            acc_l     <= '0;
            acc_r     <= '0;
            voice_sel <= '0;
         end
         if (accept) begin
            acc_l <= acc_l + add_l;
            acc_r <= acc_r + add_r;
         end
         if (state == NEXT && next_state == REQ) voice_sel <= voice_sel + 4'd1;
         if (state == MIX) begin
            l          <= sat16(acc_l);
            r          <= sat16(acc_r);
            frame_done <= 1'b1;
         end

         // A flag event in the same cycle as clr_flags takes priority.
         if (tick && state != IDLE) overrun <= 1'b1;
         else if (clr_flags)        overrun <= 1'b0;
         missed <= (clr_flags ? '0 : missed) | miss_mask;
      end
   end

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
`timescale 1ns/1ps
module tb_i2s_frame_scheduler;

   localparam int V      = 4;
   localparam int TO     = 64;
   localparam int CLK_HZ = 25000000;
   localparam int LR     = 44100;
   localparam int LR2    = 41667;   // ticks roughly every 600 cycles
   localparam int TO2    = 255;
   localparam int NEVER  = 1000;    // ack delay that never comes

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic          rst, enable, voice_req, voice_ack, frame_done, overrun, clr_flags;
   logic [3:0]    voice_sel;
   logic [15:0]   voice_l, voice_r, l, r;
   logic [V-1:0]  missed;

   // overrun instance (never acked)
   logic          rst2, enable2, req2, ack2, done2, ovr2, clr2;
   logic [3:0]    sel2;
   logic [15:0]   vl2, vr2, l2, r2;
   logic [V-1:0]  missed2;

   i2s_frame_scheduler #(.VOICES(V), .CLK_HZ(CLK_HZ), .LRCK_HZ(LR), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .enable(enable), .voice_req(voice_req), .voice_sel(voice_sel),
      .voice_ack(voice_ack), .voice_l(voice_l), .voice_r(voice_r), .l(l), .r(r),
      .frame_done(frame_done), .overrun(overrun), .missed(missed), .clr_flags(clr_flags));

   i2s_frame_scheduler #(.VOICES(V), .CLK_HZ(CLK_HZ), .LRCK_HZ(LR2), .TIMEOUT(TO2)) dut_ovr (
      .clk(clk), .rst(rst2), .enable(enable2), .voice_req(req2), .voice_sel(sel2),
      .voice_ack(ack2), .voice_l(vl2), .voice_r(vr2), .l(l2), .r(r2),
      .frame_done(done2), .overrun(ovr2), .missed(missed2), .clr_flags(clr2));

   int           n_checks = 0;
   int           n_err    = 0;
   int           cyc      = 0;
   logic [V-1:0] missed_exp;
   longint       inc1, inc2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   // Cycle (counted from the first enabled edge) whose add produces carry number k.
   function automatic longint tick_at(input longint k, input longint inc);
      return (k * (longint'(1) << 32) + inc - 1) / inc;
   endfunction

   function automatic logic [15:0] clamp16(input int s);
      if (s > 32767)  return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return 16'(s);
   endfunction

   // Serves one frame as the voice bus responder and checks the outcome.
   // dly[i] = REQ cycles voice i waits before acking (NEVER = no ack).
   // clr_on  = voice whose timeout cycle also carries clr_flags (-1: none).
   task automatic run_frame(input string tag, input logic [15:0] ls[V], input logic [15:0] rs[V],
                            input int dly[V], input int clr_on, output int t_first);
      logic [15:0]  pl, pr, el, er;
      logic [V-1:0] tmask, newm;
      int t_start, t_done, cnt, cur, nreq, sum_l, sum_r, lat;
      bit in_req, order_ok, hold_ok;
      t_start = -1; t_done = -1; cnt = 0; cur = 0; nreq = 0;
      sum_l = 0; sum_r = 0; lat = 1; tmask = '0;
      in_req = 0; order_ok = 1; hold_ok = 1;
      for (int i = 0; i < V; i++) begin
         if (dly[i] < TO) begin
            sum_l += int'($signed(ls[i]));
            sum_r += int'($signed(rs[i]));
            lat   += dly[i] + 2;
         end else begin
            tmask[i] = 1'b1;
            lat     += TO + 1;
         end
      end
      el = clamp16(sum_l);
      er = clamp16(sum_r);
      if (clr_on >= 0) begin
         newm = '0;
         for (int i = 0; i < V; i++) if (i >= clr_on) newm[i] = tmask[i];
         missed_exp = newm;
      end else begin
         missed_exp = missed_exp | tmask;
      end
      pl = l; pr = r;
      for (int i = 0; i < 1500 && t_done < 0; i++) begin
         step();
         clr_flags = 1'b0;
         if (frame_done === 1'b1) begin
            t_done = cyc;
         end else begin
            if (l !== pl || r !== pr) hold_ok = 0;
            if (voice_req === 1'b1) begin
               if (t_start < 0) t_start = cyc;
               if (!in_req) begin
                  in_req = 1; cnt = 0; cur = int'(voice_sel);
                  if (cur != nreq) order_ok = 0;
                  nreq++;
               end
               if (cur < V && cnt == dly[cur]) begin
                  voice_ack = 1'b1; voice_l = ls[cur]; voice_r = rs[cur];
               end else begin
                  voice_ack = 1'b0; voice_l = 16'($urandom); voice_r = 16'($urandom);
               end
               if (cur == clr_on && cnt == TO - 1) clr_flags = 1'b1;
               cnt++;
            end else begin
               // ack outside REQ carries junk that must be ignored
               in_req = 0;
               voice_ack = 1'($urandom_range(0, 1));
               voice_l = 16'($urandom); voice_r = 16'($urandom);
            end
         end
      end
      voice_ack = 1'b0; clr_flags = 1'b0;
      check({tag, " frame_done_seen"}, 32'(t_done >= 0), 32'd1);
      check({tag, " l"}, l, el);
      check({tag, " r"}, r, er);
      check({tag, " latency"}, t_done - t_start, lat);
      check({tag, " sel_order"}, {31'd0, order_ok}, 32'd1);
      check({tag, " voices_polled"}, nreq, V);
      check({tag, " lr_hold_until_done"}, {31'd0, hold_ok}, 32'd1);
      check({tag, " missed"}, missed, missed_exp);
      check({tag, " overrun"}, overrun, 1'b0);
      step();
      check({tag, " done_one_cycle"}, frame_done, 1'b0);
      check({tag, " l_hold"}, l, el);
      t_first = t_start;
   endtask

   initial begin
      logic [15:0] ls[V], rs[V], bl[V], z[V];
      int dly[V], d0[V];
      int k, c0, tf, nd;
      bit found;
      int dq[$], eq[$];
      longint last, t;
      bit ovr_exp;

      inc1 = ((longint'(1) << 32) * LR) / CLK_HZ;
      inc2 = ((longint'(1) << 32) * LR2) / CLK_HZ;
      bl = '{16'h0100, 16'h0200, 16'hFF00, 16'h0010};
      z  = '{16'h0, 16'h0, 16'h0, 16'h0};
      d0 = '{0, 0, 0, 0};

      rst = 1; enable = 0; voice_ack = 0; voice_l = 0; voice_r = 0; clr_flags = 0;
      rst2 = 1; enable2 = 0; ack2 = 0; vl2 = 0; vr2 = 0; clr2 = 0;
      missed_exp = '0;
      repeat (3) step();
      check("rst voice_req", voice_req, 1'b0);
      check("rst voice_sel", voice_sel, 4'd0);
      check("rst l", l, 16'h0);
      check("rst r", r, 16'h0);
      check("rst frame_done", frame_done, 1'b0);
      check("rst overrun", overrun, 1'b0);
      check("rst missed", missed, '0);

      // Tick spacing: no acks, so every frame times out on all voices.
      rst = 0; enable = 1; c0 = cyc; k = 0;
      for (int i = 0; i < 12000 && k < 20; i++) begin
         step();
         if (frame_done === 1'b1) begin
            k++;
            check($sformatf("tick frame%0d time", k), cyc - c0,
                  32'(tick_at(k, inc1) + 2 + V * (TO + 1)));
         end
      end
      check("tick frame count", k, 20);
      check("all timeout missed", missed, 4'hF);
      check("no overrun at 44k1", overrun, 1'b0);
      clr_flags = 1; step(); clr_flags = 0;
      check("clr missed", missed, 4'h0);
      missed_exp = '0;

      run_frame("basic", bl, z, d0, -1, tf);
      ls = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
      rs = '{16'h9000, 16'h9000, 16'h9000, 16'h9000};
      run_frame("saturate", ls, rs, d0, -1, tf);
      for (int i = 0; i < V; i++) begin ls[i] = 16'($urandom); rs[i] = 16'($urandom); end
      dly = '{0, 1, NEVER, 2};
      run_frame("timeout v2", ls, rs, dly, -1, tf);
      check("missed v2 only", missed, 4'b0100);
      clr_flags = 1; step(); clr_flags = 0;
      check("clr after timeout", missed, 4'h0);
      missed_exp = '0;
      dly = '{NEVER, 0, 0, NEVER};
      run_frame("set wins over clr", ls, rs, dly, 3, tf);

      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < V; i++) begin
            ls[i]  = 16'($urandom); rs[i] = 16'($urandom);
            dly[i] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 3));
         end
         run_frame($sformatf("rand%0d", f), ls, rs, dly, -1, tf);
      end
      run_frame("basic2", bl, z, d0, -1, tf);

      // Reset while voice 1 is being polled.
      found = 0;
      for (int i = 0; i < 1500 && !found; i++) begin
         step();
         if (voice_req === 1'b1 && voice_sel == 4'd1) begin
            found = 1; voice_ack = 0; rst = 1;
         end else if (voice_req === 1'b1) begin
            voice_ack = 1; voice_l = 16'h1234; voice_r = 16'h4321;
         end else begin
            voice_ack = 0;
         end
      end
      check("reach voice1", {31'd0, found}, 32'd1);
      step();
      check("midrst voice_req", voice_req, 1'b0);
      check("midrst l", l, 16'h0);
      check("midrst r", r, 16'h0);
      check("midrst missed", missed, '0);
      check("midrst overrun", overrun, 1'b0);
      rst = 0; c0 = cyc; missed_exp = '0;
      run_frame("post reset", bl, z, d0, -1, tf);
      check("post reset first req", tf - c0, 32'(tick_at(1, inc1) + 1));

      // enable=0 holds the phase: no frames at all.
      enable = 0; nd = 0;
      for (int i = 0; i < 1500; i++) begin
         step();
         if (frame_done === 1'b1 || voice_req === 1'b1) nd++;
      end
      check("disabled no activity", nd, 0);
      enable = 1;

      // Overrun instance: 1026-cycle frames against 600-cycle ticks.
      rst2 = 0; enable2 = 1; c0 = cyc;
      for (int i = 0; i < 4000; i++) begin
         step();
         if (done2 === 1'b1) dq.push_back(cyc - c0);
      end
      last = -100000; ovr_exp = 0;
      for (longint kk = 1; tick_at(kk, inc2) <= 4000; kk++) begin
         t = tick_at(kk, inc2);
         if (t > last + 1025) begin
            last = t;
            if (t + 1026 <= 4000) eq.push_back(int'(t + 1026));
         end else begin
            ovr_exp = 1;
         end
      end
      check("ovr frame count", dq.size(), eq.size());
      for (int i = 0; i < eq.size() && i < dq.size(); i++)
         check($sformatf("ovr frame%0d time", i), dq[i], eq[i]);
      check("ovr flag", ovr2, ovr_exp);
      check("ovr missed", missed2, 4'hF);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
